// File: rtl/project_soc_pkg.sv
// project_soc_pkg: shared register offsets and edge-type encodings for SoC bus ports
package project_soc_pkg;
    localparam logic [1:0] DATA     = 2'd0;
    localparam logic [1:0] RESERVED = 2'd1;
    localparam logic [1:0] IRQ_MASK = 2'd2;
    localparam logic [1:0] EDGE_CAP = 2'd3;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/project_soc_sync2.sv
// project_soc_sync2: WIDTH-bit two-flop synchronizer, async active-low reset
//   clk, reset_n : clock and asynchronous active-low reset
//   d_i          : asynchronous input bits
//   q_o          : bits synchronized to clk, two cycles later
module project_soc_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end
    assign q_o = sync_q;
endmodule

// File: rtl/project_soc_usb_irq_in.sv
// project_soc_usb_irq_in: Avalon-MM input port with sticky edge capture and maskable irq
//   clk, reset_n          : clock and asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    : Avalon-MM slave write side (0 DATA, 1 reserved, 2 IRQ_MASK, 3 EDGE_CAP)
//   in_port               : external input level(s)
//   readdata              : registered read data, zero-extended, 1-cycle latency
//   irq                   : OR of EDGE_CAP & IRQ_MASK
//   Define USB_IRQ_IN_SYNC_EN to insert a two-flop synchronizer on in_port.
module project_soc_usb_irq_in
    import project_soc_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr;
    logic             unused_wdata;

`ifdef USB_IRQ_IN_SYNC_EN
    project_soc_sync2 #(.WIDTH(WIDTH)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (in_port),
        .q_o     (s)
    );
`else
    assign s = in_port;
`endif

    // only writedata[WIDTH-1:0] is meaningful; the rest is deliberately ignored
    assign unused_wdata = ^writedata;

    always_comb begin
        wr = chipselect && !write_n;
        edges = EDGE_TYPE == EDGE_RISE ? s & ~prev_q :
                EDGE_TYPE == EDGE_FALL ? ~s & prev_q : s ^ prev_q;
        mask_d = (wr && address == IRQ_MASK) ? writedata[WIDTH-1:0] : mask_q;
        // edges are ORed after the clear so a same-cycle edge always survives
        cap_d = ((wr && address == EDGE_CAP) ? cap_q & ~writedata[WIDTH-1:0] : cap_q) | edges;
        readdata_d = address == DATA     ? 32'(s) :
                     address == IRQ_MASK ? 32'(mask_q) :
                     address == EDGE_CAP ? 32'(cap_q) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= s;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);
endmodule

// File: tb/tb_project_soc_usb_irq_in.sv
// tb_project_soc_usb_irq_in: table-driven and sequence checks with a read scoreboard
module tb_project_soc_usb_irq_in;
`ifdef USB_IRQ_IN_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif
    logic        clk = 0;
    logic        reset_n = 0;
    logic [1:0]  address = 0;
    logic        chipselect = 0;
    logic        write_n = 1;
    logic [31:0] writedata = 0;
    logic        inp = 0;
    logic [3:0]  inp4 = 0;
    logic [31:0] rd, rd4;
    logic        irq, irq4;
    int          n = 0;
    int          errs = 0;
    logic [31:0] exp_q[$];

    project_soc_usb_irq_in #(.WIDTH(1), .EDGE_TYPE(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(inp), .readdata(rd), .irq(irq)
    );

    project_soc_usb_irq_in #(.WIDTH(4), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(inp4), .readdata(rd4), .irq(irq4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  a;
        logic        w;
        logic [31:0] wd;
        logic        inp;
        logic        rc;
        logic [31:0] er;
        logic        ic;
        logic        ei;
    } vec_t;

    vec_t tbl [31];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] a, input logic w, input logic [31:0] wd);
        @(negedge clk);
        address = a;
        chipselect = 1;
        write_n = !w;
        writedata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(2'd0, 1'b0, 32'd0);
    endtask

    task automatic rd_check(input logic which, input logic [1:0] a, input logic [31:0] e, input string name);
        logic [31:0] x;
        exp_q.push_back(e);
        cyc(a, 1'b0, 32'd0);
        x = exp_q.pop_front();
        chk(name, which ? rd4 : rd, x);
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 1, 0, 1, 0};
        tbl[1]  = '{2, 0, 0, 0, 1, 0, 1, 0};
        tbl[2]  = '{3, 0, 0, 0, 1, 0, 1, 0};
        tbl[3]  = '{1, 0, 0, 0, 1, 0, 1, 0};
        tbl[4]  = '{2, 1, 1, 0, 1, 0, 1, 0};
        tbl[5]  = '{2, 0, 0, 0, 1, 1, 1, 0};
        tbl[6]  = '{0, 0, 0, 1, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 1, 1, 1, 1};
        tbl[10] = '{3, 0, 0, 1, 1, 1, 1, 1};
        tbl[11] = '{3, 1, 1, 1, 1, 1, 1, 0};
        tbl[12] = '{3, 0, 0, 1, 1, 0, 1, 0};
        tbl[13] = '{3, 0, 0, 1, 1, 0, 1, 0};
        tbl[14] = '{2, 1, 0, 1, 1, 1, 1, 0};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 1, 0};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 1, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 1, 0};
        tbl[18] = '{3, 0, 0, 0, 1, 0, 1, 0};
        tbl[19] = '{0, 0, 0, 1, 0, 0, 1, 0};
        tbl[20] = '{0, 0, 0, 1, 0, 0, 1, 0};
        tbl[21] = '{0, 0, 0, 1, 0, 0, 1, 0};
        tbl[22] = '{3, 0, 0, 1, 1, 1, 1, 0};
        tbl[23] = '{2, 1, 1, 1, 1, 0, 1, 1};
        tbl[24] = '{0, 1, 0, 1, 1, 1, 1, 1};
        tbl[25] = '{1, 1, 32'hFFFF_FFFF, 1, 1, 0, 1, 1};
        tbl[26] = '{0, 0, 0, 1, 1, 1, 1, 1};
        tbl[27] = '{2, 0, 0, 1, 1, 1, 1, 1};
        tbl[28] = '{3, 1, 1, 1, 1, 1, 1, 0};
        tbl[29] = '{2, 1, 32'hFFFF_FFFE, 1, 1, 1, 1, 0};
        tbl[30] = '{2, 0, 0, 1, 1, 0, 1, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1;

        for (int i = 0; i < 31; i++) begin
            logic [31:0] x;
            inp = tbl[i].inp;
            if (tbl[i].rc) exp_q.push_back(tbl[i].er);
            cyc(tbl[i].a, tbl[i].w, tbl[i].wd);
            if (tbl[i].rc) begin
                x = exp_q.pop_front();
                chk($sformatf("vec%0d_rd", i), rd, x);
            end
            if (tbl[i].ic) chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].ei});
        end

        // exact capture latency, then clear coinciding with a new edge
        cyc(2'd2, 1'b1, 32'd1);
        inp = 0;
        idle(3);
        inp = 1;
        for (int i = 0; i <= D; i++) begin
            cyc(i == D ? 2'd3 : 2'd0, i == D, 32'd1);
            if (i == D - 1) chk("lat_pre_irq", {31'd0, irq}, 32'd0);
        end
        chk("set_wins_irq", {31'd0, irq}, 32'd1);
        rd_check(1'b0, 2'd3, 32'd1, "set_wins_cap");
        rd_check(1'b0, 2'd0, 32'd1, "data_high");

        // asynchronous reset mid-operation with the input held high
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rd", rd, 32'd0);
        @(negedge clk);
        reset_n = 1;
        idle(D + 2);
        chk("rst_mask_irq", {31'd0, irq}, 32'd0);
        rd_check(1'b0, 2'd3, 32'd1, "rst_rise_cap");
        rd_check(1'b0, 2'd2, 32'd0, "rst_mask");
        cyc(2'd3, 1'b1, 32'd1);
        idle(3);
        rd_check(1'b0, 2'd3, 32'd0, "capture_once");

        // any-edge instance, 4 bits wide
        cyc(2'd2, 1'b1, 32'hFFFF_FFFF);
        rd_check(1'b1, 2'd2, 32'hF, "any_mask");
        inp4 = 4'b0101;
        idle(D + 1);
        chk("any_rise_irq", {31'd0, irq4}, 32'd1);
        rd_check(1'b1, 2'd3, 32'h5, "any_rise_cap");
        cyc(2'd3, 1'b1, 32'hF);
        idle(2);
        chk("any_clr_irq", {31'd0, irq4}, 32'd0);
        rd_check(1'b1, 2'd3, 32'h0, "any_clr_cap");
        inp4 = 4'b0000;
        idle(D + 1);
        rd_check(1'b1, 2'd3, 32'h5, "any_fall_cap");
        cyc(2'd3, 1'b1, 32'h1);
        rd_check(1'b1, 2'd3, 32'h4, "any_partial_clr");
        cyc(2'd3, 1'b1, 32'hF);
        inp4 = 4'b1010;
        idle(D + 1);
        rd_check(1'b1, 2'd3, 32'hA, "any_cap_a");
        rd_check(1'b1, 2'd0, 32'hA, "any_data");
        cyc(2'd0, 1'b1, 32'h5);
        cyc(2'd1, 1'b1, 32'hF);
        rd_check(1'b1, 2'd0, 32'hA, "any_data_wr_ign");
        rd_check(1'b1, 2'd1, 32'h0, "any_reserved");

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
